// File: rtl/sched_pkg.sv
// Shared types, default parameters and helpers for the pc_scheduler slice.
package sched_pkg;

  localparam int NPROC_DEF   = 4;
  localparam int PC_W_DEF    = 32;
  localparam int QUANTUM_DEF = 16;
  localparam int PROC_ID_W   = $clog2(NPROC_DEF);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SAVE   = 3'd2,
    ST_SELECT = 3'd3,
    ST_LOAD   = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_t;

  localparam sched_state_t RST_STATE = ST_IDLE;
  localparam logic         RST_FLAG  = 1'b0;

  // The datapath is frozen in every state that is part of a switch or the final halt.
  function automatic logic is_stall_state(input sched_state_t s);
    case (s)
      ST_SAVE, ST_SELECT, ST_LOAD, ST_DONE: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_scheduler_rr_picker.sv
// rr_picker: combinational round-robin search over the active mask,
// returning the first active slot at or after 'start' (wrapping).
module rr_picker
  import sched_pkg::*;
#(
  parameter int NPROC = NPROC_DEF
) (
  input  logic [NPROC-1:0]         active,
  input  logic [$clog2(NPROC)-1:0] start,
  output logic [$clog2(NPROC)-1:0] sel,
  output logic                     found
);

  localparam int ID_W = $clog2(NPROC);

  logic [ID_W-1:0] idx_s;

  // Walk offsets from far to near so the nearest active slot is the last one kept.
  always_comb begin
    idx_s = start;
    sel   = start;
    found = |active;
    for (int i = NPROC - 1; i >= 0; i--) begin
      idx_s = start + ID_W'(i);
      sel   = active[idx_s] ? idx_s : sel;
    end
  end

endmodule

// File: rtl/pc_scheduler.sv
// pc_scheduler: round-robin time-slice scheduler in front of the PC register.
// Optional macro SCHED_STATS_EN adds the switchCnt context-switch counter output.
module pc_scheduler
  import sched_pkg::*;
#(
  parameter int NPROC   = NPROC_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int QUANTUM = QUANTUM_DEF
) (
  input  logic                     clock,
  input  logic                     resetCPU,
  input  logic                     enable,
  input  logic                     cfgWe,
  input  logic [$clog2(NPROC)-1:0] cfgId,
  input  logic [PC_W-1:0]          cfgPc,
  input  logic                     yield,
  input  logic                     procExit,
  input  logic [PC_W-1:0]          pcAtual,
  input  logic [PC_W-1:0]          pcNextIn,
  output logic [PC_W-1:0]          pcNext,
  output logic                     stall,
  output logic                     isHalt,
  output logic [$clog2(NPROC)-1:0] procId
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]              switchCnt
`endif
);

  localparam int ID_W  = $clog2(NPROC);
  localparam int CNT_W = $clog2(QUANTUM);

  sched_state_t    state_r;
  sched_state_t    state_nxt_s;
  logic [ID_W-1:0] proc_id_r;
  logic [ID_W-1:0] sel_r;
  logic [CNT_W-1:0] slice_cnt_r;
  logic            from_idle_r;
  logic            stall_r;
  logic            halt_r;
  logic [NPROC-1:0] active_r;
  logic [PC_W-1:0] table_r [NPROC];

  logic [ID_W-1:0] start_s;
  logic [ID_W-1:0] pick_sel_s;
  logic            pick_found_s;
  logic            slice_end_s;

  assign slice_end_s = (slice_cnt_r == CNT_W'(QUANTUM - 1));
  // Leaving IDLE resumes at the current slot; any other search skips it until last.
  assign start_s     = from_idle_r ? proc_id_r : proc_id_r + ID_W'(1);

  rr_picker #(.NPROC(NPROC)) u_picker (
    .active (active_r),
    .start  (start_s),
    .sel    (pick_sel_s),
    .found  (pick_found_s)
  );

  // Next-state decision; exit beats yield beats expiry beats enable loss.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && (|active_r)) state_nxt_s = ST_SELECT;
        else                       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (procExit)                             state_nxt_s = ST_SELECT;
        else if (yield || slice_end_s || !enable) state_nxt_s = ST_SAVE;
        else                                      state_nxt_s = ST_RUN;
      end
      ST_SAVE:   state_nxt_s = enable ? ST_SELECT : ST_IDLE;
      ST_SELECT: state_nxt_s = pick_found_s ? ST_LOAD : ST_DONE;
      ST_LOAD:   state_nxt_s = ST_RUN;
      ST_DONE:   state_nxt_s = ST_DONE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus registered stall and one-shot halt flags.
  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      state_r     <= RST_STATE;
      from_idle_r <= RST_FLAG;
      stall_r     <= RST_FLAG;
      halt_r      <= RST_FLAG;
    end else begin
      state_r     <= state_nxt_s;
      from_idle_r <= (state_r == ST_IDLE);
      stall_r     <= is_stall_state(state_nxt_s);
      halt_r      <= (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
    end
  end

  // Current slot, latched selection and slice counter.
  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      proc_id_r   <= '0;
      sel_r       <= '0;
      slice_cnt_r <= '0;
    end else begin
      if (state_r == ST_SELECT) sel_r <= pick_sel_s;
      if (state_r == ST_LOAD) begin
        proc_id_r   <= sel_r;
        slice_cnt_r <= '0;
      end else if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
        slice_cnt_r <= slice_cnt_r + CNT_W'(1);
      end
    end
  end

  // Saved-PC table and active mask; configuration only lands while idle.
  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      active_r <= '0;
      for (int i = 0; i < NPROC; i++) table_r[i] <= '0;
    end else begin
      if ((state_r == ST_IDLE) && cfgWe) begin
        table_r[cfgId]  <= cfgPc;
        active_r[cfgId] <= 1'b1;
      end
      if ((state_r == ST_RUN) && procExit) active_r[proc_id_r] <= 1'b0;
      if (state_r == ST_SAVE) table_r[proc_id_r] <= pcNextIn;
    end
  end

  // PC mux: datapath value while running, held PC while switching, restored PC on load.
  always_comb begin
    pcNext = pcNextIn;
    case (state_r)
      ST_IDLE, ST_RUN:             pcNext = pcNextIn;
      ST_SAVE, ST_SELECT, ST_DONE: pcNext = pcAtual;
      ST_LOAD:                     pcNext = table_r[sel_r];
      default:                     pcNext = pcNextIn;
    endcase
  end

  assign stall  = stall_r;
  assign isHalt = halt_r;
  assign procId = proc_id_r;

`ifdef SCHED_STATS_EN
  logic [31:0] switch_cnt_r;

  // Saturating count of completed context loads.
  always_ff @(posedge clock or negedge resetCPU) begin
    if (!resetCPU) begin
      switch_cnt_r <= 32'd0;
    end else if ((state_r == ST_LOAD) && (switch_cnt_r != 32'hFFFF_FFFF)) begin
      switch_cnt_r <= switch_cnt_r + 32'd1;
    end
  end

  assign switchCnt = switch_cnt_r;
`endif

endmodule
